// File: rtl/dom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dom_pkg
// Description : Shared types and helpers for the 3-share DOM mask encoder.
//               FSM state encoding, zero-seed substitute, PRNG slice
//               indices and the xorshift64 step function.
// Revision    : 1.0 - initial release
// ============================================================================
package dom_pkg;

  // FSM states. The ST_ prefix keeps these clear of the WARMUP parameter.
  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2
  } dom_state_e;

  // xorshift64 has a fixed point at zero, so an all-zero seed is replaced.
  localparam logic [63:0] ZERO_SEED_SUB = 64'h9E37_79B9_7F4A_7C15;

  // Positions of each W-bit slice within the 64-bit PRNG word.
  localparam int SLICE_A0  = 0;
  localparam int SLICE_A1  = 1;
  localparam int SLICE_B0  = 2;
  localparam int SLICE_B1  = 3;
  localparam int SLICE_R01 = 4;
  localparam int SLICE_R02 = 5;
  localparam int SLICE_R12 = 6;

  // One xorshift64 step (13/7/17, logical shifts).
  function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dom_xorshift64.sv
`default_nettype none
// ============================================================================
// Module      : dom_xorshift64
// Description : Combinational next-state logic for a 64-bit xorshift PRNG.
//               Shared by the DOM gadgets that need fresh randomness.
// Ports       : state      in  64  current PRNG value
//               next_state out 64  PRNG value after one step
// Revision    : 1.0 - initial release
// ============================================================================
module dom_xorshift64
  import dom_pkg::*;
(
  input  logic [63:0] state,
  output logic [63:0] next_state
);

  assign next_state = xorshift64_step(state);

endmodule
`default_nettype wire

// File: rtl/dom_mask_encoder.sv
`default_nettype none
// ============================================================================
// Module      : dom_mask_encoder
// Description : Transmit end of the 3-share DOM datapath. Splits plaintext
//               operands a and b into three Boolean shares each and supplies
//               the three fresh randomness words for the Domand gadget. Masks
//               come from a reseedable internal xorshift64 PRNG.
// Ports       : clk, rst_n              clock / async active-low reset
//               seed, seed_valid        PRNG seed load (any state)
//               in_valid, in_ready, a, b   input handshake and operands
//               out_valid, out_ready    output handshake
//               a0..a2, b0..b2          shares of a and b
//               r01, r02, r12           gadget randomness
//               seeded                  high while in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module dom_mask_encoder
  import dom_pkg::*;
#(
  parameter int W      = 8,   // 7*W must not exceed 64
  parameter int WARMUP = 16   // PRNG steps discarded after each seed load
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   seed,
  input  logic          seed_valid,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  a0,
  output logic [W-1:0]  a1,
  output logic [W-1:0]  a2,
  output logic [W-1:0]  b0,
  output logic [W-1:0]  b1,
  output logic [W-1:0]  b2,
  output logic [W-1:0]  r01,
  output logic [W-1:0]  r02,
  output logic [W-1:0]  r12,
  output logic          seeded
);

  localparam int             CW        = $clog2(WARMUP + 1);
  localparam logic [CW-1:0]  WARM_LAST = CW'(WARMUP - 1);

  dom_state_e     r_state;
  logic [63:0]    r_prng;
  logic [CW-1:0]  r_cnt;
  logic           r_out_valid;
  logic [W-1:0]   r_a0, r_a1, r_a2, r_b0, r_b1, r_b2, r_r01, r_r02, r_r12;

  logic [63:0]    w_prng_next;
  logic           w_accept;
  logic [W-1:0]   w_s_a0, w_s_a1, w_s_b0, w_s_b1, w_s_r01, w_s_r02, w_s_r12;

  dom_xorshift64 u_prng_step (
    .state      (r_prng),
    .next_state (w_prng_next)
  );

  // A seed strobe blocks acceptance in the same cycle so the load wins.
  assign in_ready = (r_state == ST_RUN) && !seed_valid && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_s_a0  = r_prng[SLICE_A0  * W +: W];
  assign w_s_a1  = r_prng[SLICE_A1  * W +: W];
  assign w_s_b0  = r_prng[SLICE_B0  * W +: W];
  assign w_s_b1  = r_prng[SLICE_B1  * W +: W];
  assign w_s_r01 = r_prng[SLICE_R01 * W +: W];
  assign w_s_r02 = r_prng[SLICE_R02 * W +: W];
  assign w_s_r12 = r_prng[SLICE_R12 * W +: W];

  // Control FSM, PRNG and warmup counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_UNSEEDED;
      r_prng  <= 64'd0;
      r_cnt   <= '0;
    end else if (seed_valid) begin
      r_state <= ST_WARMUP;
      r_prng  <= (seed == 64'd0) ? ZERO_SEED_SUB : seed;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          r_prng <= w_prng_next;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == WARM_LAST) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Advance only on consumption so no mask is ever used twice.
          if (w_accept) begin
            r_prng <= w_prng_next;
          end
        end
        default: begin
          r_state <= ST_UNSEEDED;
        end
      endcase
    end
  end

  // Output register stage. A seed load does not touch it, so a pending
  // beat drains normally across a reseed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_a0  <= '0;
      r_a1  <= '0;
      r_a2  <= '0;
      r_b0  <= '0;
      r_b1  <= '0;
      r_b2  <= '0;
      r_r01 <= '0;
      r_r02 <= '0;
      r_r12 <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_a0  <= w_s_a0;
      r_a1  <= w_s_a1;
      r_a2  <= a ^ w_s_a0 ^ w_s_a1;
      r_b0  <= w_s_b0;
      r_b1  <= w_s_b1;
      r_b2  <= b ^ w_s_b0 ^ w_s_b1;
      r_r01 <= w_s_r01;
      r_r02 <= w_s_r02;
      r_r12 <= w_s_r12;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign a0        = r_a0;
  assign a1        = r_a1;
  assign a2        = r_a2;
  assign b0        = r_b0;
  assign b1        = r_b1;
  assign b2        = r_b2;
  assign r01       = r_r01;
  assign r02       = r_r02;
  assign r12       = r_r12;
  assign seeded    = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_dom_mask_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dom_mask_encoder
// Description : Self-checking bench for dom_mask_encoder. A golden xorshift64
//               model predicts every beat; expected beats are queued when
//               driven and popped when the encoder presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dom_mask_encoder;

  typedef struct packed {
    logic [7:0] a0, a1, a2, b0, b1, b2, r01, r02, r12, pa, pb;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] seed = 64'd0;
  logic        seed_valid = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  a0, a1, a2, b0, b1, b2, r01, r02, r12;
  logic        seeded;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] m_prng;
  beat_t       exp_q[$];
  beat_t       last_beat;

  always #5 clk = ~clk;

  dom_mask_encoder #(.W(8), .WARMUP(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed       (seed),
    .seed_valid (seed_valid),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a0         (a0),
    .a1         (a1),
    .a2         (a2),
    .b0         (b0),
    .b1         (b1),
    .b2         (b2),
    .r01        (r01),
    .r02        (r02),
    .r12        (r12),
    .seeded     (seeded)
  );

  function automatic logic [63:0] gold_step(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic beat_t make_beat(input logic [63:0] p, input logic [7:0] pa,
                                      input logic [7:0] pb);
    beat_t e;
    e.a0  = p[7:0];
    e.a1  = p[15:8];
    e.a2  = pa ^ p[7:0] ^ p[15:8];
    e.b0  = p[23:16];
    e.b1  = p[31:24];
    e.b2  = pb ^ p[23:16] ^ p[31:24];
    e.r01 = p[39:32];
    e.r02 = p[47:40];
    e.r12 = p[55:48];
    e.pa  = pa;
    e.pb  = pb;
    return e;
  endfunction

  function automatic logic [71:0] dut_shares();
    return {a0, a1, a2, b0, b1, b2, r01, r02, r12};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({in_ready, out_valid, seeded, dut_shares()} !== 75'd0 || dut.r_prng !== 64'd0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%0b ov=%0b sd=%0b sh=%h prng=%h, need all zero",
               in_ready, out_valid, seeded, dut_shares(), dut.r_prng);
    end
    rst_n = 1'b1;
    in_valid = 1'b1;
    a = 8'hA5;
    b = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if ({in_ready, out_valid, seeded, dut_shares()} !== 75'd0) begin
        n_err++;
        $display("FAIL unseeded_idle cyc %0d: got rdy=%0b ov=%0b sd=%0b sh=%h, need all zero",
                 i, in_ready, out_valid, seeded, dut_shares());
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_seed_warmup();
    seed = 64'h1;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    m_prng = 64'h1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      m_prng = gold_step(m_prng);
      if (i == 15) begin
        n_cmp++;
        if (seeded !== 1'b0 || in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL warmup_early: got seeded=%0b in_ready=%0b after 15 steps, need 0/0",
                   seeded, in_ready);
        end
      end
    end
    n_cmp++;
    if (seeded !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL warmup_done: got seeded=%0b in_ready=%0b after 16 steps, need 1/1",
               seeded, in_ready);
    end
    n_cmp++;
    if (dut.r_prng !== m_prng) begin
      n_err++;
      $display("FAIL warmup_prng: got %h need %h", dut.r_prng, m_prng);
    end
  endtask

  task automatic test_accept();
    beat_t e;
    out_ready = 1'b1;
    a = 8'hA5;
    b = 8'h3C;
    in_valid = 1'b1;
    #1;
    exp_q.push_back(make_beat(m_prng, a, b));
    m_prng = gold_step(m_prng);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL accept_valid: got out_valid=%0b need 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      last_beat = e;
      n_cmp++;
      if (dut_shares() !== {e.a0, e.a1, e.a2, e.b0, e.b1, e.b2, e.r01, e.r02, e.r12}) begin
        n_err++;
        $display("FAIL accept_slices: got %h need %h", dut_shares(),
                 {e.a0, e.a1, e.a2, e.b0, e.b1, e.b2, e.r01, e.r02, e.r12});
      end
      n_cmp++;
      if ((a0 ^ a1 ^ a2) !== 8'hA5 || (b0 ^ b1 ^ b2) !== 8'h3C) begin
        n_err++;
        $display("FAIL accept_unmask: got a=%h b=%h need a=a5 b=3c", a0 ^ a1 ^ a2, b0 ^ b1 ^ b2);
      end
      n_cmp++;
      if ({a0, a1, b0, b1, r01, r02, r12} === 56'd0) begin
        n_err++;
        $display("FAIL accept_nonzero: got all-zero mask slices need nonzero");
      end
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || a0 !== last_beat.a0 || r12 !== last_beat.r12) begin
      n_err++;
      $display("FAIL drain_hold: got ov=%0b a0=%h r12=%h need ov=0 a0=%h r12=%h",
               out_valid, a0, r12, last_beat.a0, last_beat.r12);
    end
  endtask

  task automatic test_backpressure();
    beat_t e;
    a = 8'h11;
    b = 8'h22;
    in_valid = 1'b1;
    #1;
    exp_q.push_back(make_beat(m_prng, a, b));
    m_prng = gold_step(m_prng);
    tick();
    out_ready = 1'b0;
    a = 8'h33;
    for (int i = 0; i < 5; i++) begin
      #1;
      e = exp_q[0];
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut.r_prng !== m_prng ||
          dut_shares() !== {e.a0, e.a1, e.a2, e.b0, e.b1, e.b2, e.r01, e.r02, e.r12}) begin
        n_err++;
        $display("FAIL stall cyc %0d: got ov=%0b rdy=%0b prng=%h sh=%h need ov=1 rdy=0 prng=%h sh=%h",
                 i, out_valid, in_ready, dut.r_prng, dut_shares(), m_prng,
                 {e.a0, e.a1, e.a2, e.b0, e.b1, e.b2, e.r01, e.r02, e.r12});
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    void'(exp_q.pop_front());
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_single_beat: got ov=%0b pending=%0d need ov=0 pending=0",
               out_valid, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    beat_t e;
    logic [7:0] c0, c1, c2;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 0) begin
        a = 8'hA5;
        b = 8'h3C;
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      in_valid = 1'b1;
      exp_q.push_back(make_beat(m_prng, a, b));
      m_prng = gold_step(m_prng);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        n_err++;
        $display("FAIL b2b_valid beat %0d: got out_valid=%0b need 1", i, out_valid);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (dut_shares() !== {e.a0, e.a1, e.a2, e.b0, e.b1, e.b2, e.r01, e.r02, e.r12}) begin
          n_err++;
          $display("FAIL b2b_slices beat %0d: got %h need %h", i, dut_shares(),
                   {e.a0, e.a1, e.a2, e.b0, e.b1, e.b2, e.r01, e.r02, e.r12});
        end
        // Domand gadget fed directly from the encoder outputs.
        c0 = (a0 & b0) ^ ((a0 & b1) ^ r01) ^ ((a0 & b2) ^ r02);
        c1 = (a1 & b1) ^ ((a1 & b0) ^ r01) ^ ((a1 & b2) ^ r12);
        c2 = (a2 & b2) ^ ((a2 & b0) ^ r02) ^ ((a2 & b1) ^ r12);
        n_cmp++;
        if ((c0 ^ c1 ^ c2) !== (e.pa & e.pb)) begin
          n_err++;
          $display("FAIL domand beat %0d: got %h need %h", i, c0 ^ c1 ^ c2, e.pa & e.pb);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end: got out_valid=%0b need 0", out_valid);
    end
  endtask

  task automatic test_zero_seed_reseed();
    beat_t e;
    a = 8'h5A;
    b = 8'hC3;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    exp_q.push_back(make_beat(m_prng, a, b));
    m_prng = gold_step(m_prng);
    tick();
    // Hold the beat, then reseed with zero while also offering new input.
    out_ready = 1'b0;
    seed = 64'd0;
    seed_valid = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL seed_priority: got in_ready=%0b need 0", in_ready);
    end
    tick();
    seed_valid = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (dut.r_prng !== 64'h9E3779B97F4A7C15 || seeded !== 1'b0) begin
      n_err++;
      $display("FAIL zero_seed: got prng=%h seeded=%0b need 9e3779b97f4a7c15/0",
               dut.r_prng, seeded);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 ||
        dut_shares() !== {e.a0, e.a1, e.a2, e.b0, e.b1, e.b2, e.r01, e.r02, e.r12}) begin
      n_err++;
      $display("FAIL reseed_pending: got ov=%0b sh=%h need ov=1 sh=%h", out_valid, dut_shares(),
               {e.a0, e.a1, e.a2, e.b0, e.b1, e.b2, e.r01, e.r02, e.r12});
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reseed_drain: got out_valid=%0b need 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_warmup();
    // Still in WARMUP from the zero-seed load; give it a few steps first.
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (seeded !== 1'b0 || dut.r_prng !== 64'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midwarm_reset: got seeded=%0b prng=%h ov=%0b need 0/0/0",
               seeded, dut.r_prng, out_valid);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++;
    if (seeded !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midwarm_unseeded: got seeded=%0b rdy=%0b ov=%0b need 0/0/0",
               seeded, in_ready, out_valid);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seed_warmup();
    test_accept();
    test_backpressure();
    test_back_to_back();
    test_zero_seed_reseed();
    test_reset_mid_warmup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout need completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
